// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic MAC array and its preload FIFOs.
package systolic_pkg;

    localparam int DIM_DEF     = 8;
    localparam int BITS_AB_DEF = 8;
    localparam int BITS_C_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/systolic_pe.sv
// One output-stationary multiply-accumulate element. Operands are registered
// and forwarded to the right/down neighbours; the accumulator stays in place.
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int BITS_AB = BITS_AB_DEF,
    parameter int BITS_C  = BITS_C_DEF
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      clr,
    input  logic signed [BITS_AB-1:0] a_in,
    input  logic signed [BITS_AB-1:0] b_in,
    output logic signed [BITS_AB-1:0] a_out,
    output logic signed [BITS_AB-1:0] b_out,
    output logic signed [BITS_C-1:0]  c
);

    logic signed [BITS_AB-1:0]   a_r;
    logic signed [BITS_AB-1:0]   b_r;
    logic signed [2*BITS_AB-1:0] prod;
    logic signed [BITS_C-1:0]    prod_c;

    // full-precision signed product, then fitted to the accumulator width
    assign prod = a_in * b_in;

    generate
        if (BITS_C >= 2*BITS_AB) begin : g_ext
            assign prod_c = BITS_C'(prod);
        end else begin : g_trunc
            assign prod_c = prod[BITS_C-1:0];
        end
    endgenerate

    // operand pipeline and wrapping accumulator; clr wins so a new job starts clean
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r <= '0;
            b_r <= '0;
            c   <= '0;
        end else if (clr) begin
            a_r <= '0;
            b_r <= '0;
            c   <= '0;
        end else if (en) begin
            a_r <= a_in;
            b_r <= b_in;
            c   <= c + prod_c;
        end
    end

    assign a_out = a_r;
    assign b_out = b_r;

endmodule

// File: rtl/systolic_array.sv
// DIM x DIM output-stationary systolic array with a run sequencer.
// Skewed operand streams arrive from the preload FIFOs; fifo_en shifts them.
//
//   state | meaning
//   IDLE  | waiting for start; C holds the last tile
//   RUN   | FIFOs shifting, PEs accumulating for RUN_CYCLES edges
//   DONE  | tile final; done pulses for one cycle
module systolic_array
    import systolic_pkg::*;
#(
    parameter int DIM        = DIM_DEF,
    parameter int BITS_AB    = BITS_AB_DEF,
    parameter int BITS_C     = BITS_C_DEF,
    parameter int RUN_CYCLES = 4*DIM-2
)(
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [DIM-1:0][BITS_AB-1:0]         A,
    input  logic [DIM-1:0][BITS_AB-1:0]         B,
    output logic                                fifo_en,
    output logic                                busy,
    output logic                                done,
    output logic [DIM-1:0][DIM-1:0][BITS_C-1:0] C
);

    localparam int              CNT_W    = $clog2(RUN_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RUN_CYCLES-1);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic             pe_en;
    logic             pe_clr;

    logic signed [BITS_AB-1:0] a_o [DIM][DIM];
    logic signed [BITS_AB-1:0] b_o [DIM][DIM];

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // run-length counter, cleared on the accepting start edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        cnt <= '0;
        else if (state == IDLE && start) cnt <= '0;
        else if (state == RUN)          cnt <= cnt + 1'b1;
    end

    // next-state decode; start is only looked at in IDLE
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (cnt == CNT_LAST) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign pe_clr  = (state == IDLE) && start;
    assign pe_en   = (state == RUN);
    assign fifo_en = (state == RUN);
    assign busy    = (state == RUN) || (state == DONE);
    assign done    = (state == DONE);

    generate
        for (genvar gi = 0; gi < DIM; gi++) begin : g_row
            for (genvar gj = 0; gj < DIM; gj++) begin : g_col
                logic signed [BITS_AB-1:0] a_i;
                logic signed [BITS_AB-1:0] b_i;

                if (gj == 0) begin : g_a_edge
                    assign a_i = A[gi];
                end else begin : g_a_link
                    assign a_i = a_o[gi][gj-1];
                end

                if (gi == 0) begin : g_b_edge
                    assign b_i = B[gj];
                end else begin : g_b_link
                    assign b_i = b_o[gi-1][gj];
                end

                systolic_pe #(
                    .BITS_AB (BITS_AB),
                    .BITS_C  (BITS_C)
                ) u_pe (
                    .clk   (clk),
                    .rst   (rst),
                    .en    (pe_en),
                    .clr   (pe_clr),
                    .a_in  (a_i),
                    .b_in  (b_i),
                    .a_out (a_o[gi][gj]),
                    .b_out (b_o[gi][gj]),
                    .c     (C[gi][gj])
                );
            end
        end
    endgenerate

endmodule

// File: tb/tb_systolic_array.sv
// Directed bench for systolic_array: drives skewed A/B streams the way the
// preload FIFOs would, and checks each tile against a matrix-product model.
module tb_systolic_array;

    localparam int DIM        = 8;
    localparam int BITS_AB    = 8;
    localparam int BITS_C     = 16;
    localparam int RUN_CYCLES = 4*DIM-2;

    logic                                clk = 1'b0;
    logic                                rst;
    logic                                start;
    logic [DIM-1:0][BITS_AB-1:0]         A;
    logic [DIM-1:0][BITS_AB-1:0]         B;
    logic                                fifo_en;
    logic                                busy;
    logic                                done;
    logic [DIM-1:0][DIM-1:0][BITS_C-1:0] C;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t_start;
    int t_prev_start;

    int ma [DIM][DIM];
    int mb [DIM][DIM];
    logic [BITS_C-1:0] exp_q [$];
    logic [BITS_C-1:0] last_exp [DIM][DIM];

    systolic_array #(
        .DIM        (DIM),
        .BITS_AB    (BITS_AB),
        .BITS_C     (BITS_C),
        .RUN_CYCLES (RUN_CYCLES)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .A       (A),
        .B       (B),
        .fifo_en (fifo_en),
        .busy    (busy),
        .done    (done),
        .C       (C)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // reference model: C = A x B, wrapped to BITS_C
    task automatic push_expected();
        for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < DIM; j++) begin
                int s;
                s = 0;
                for (int k = 0; k < DIM; k++) s += ma[i][k] * mb[k][j];
                exp_q.push_back(BITS_C'(s));
            end
        end
    endtask

    // FIFO-equivalent feed: DIM lead zeros, then row i / column j delayed by i / j
    task automatic drive_edge(input int e);
        for (int i = 0; i < DIM; i++) begin
            int k;
            k = e - DIM - i;
            A[i] = (k >= 0 && k < DIM) ? BITS_AB'(ma[i][k]) : '0;
        end
        for (int j = 0; j < DIM; j++) begin
            int k;
            k = e - DIM - j;
            B[j] = (k >= 0 && k < DIM) ? BITS_AB'(mb[k][j]) : '0;
        end
    endtask

    task automatic run_job(input int extra_start_at, input int rst_at, input bit hold_start);
        int e;
        int guard;
        int t_req;
        push_expected();
        start = 1'b1;
        guard = 0;
        while (busy && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check("idle_before_start", busy, 0);
        t_req = cyc;
        @(posedge clk); #1;
        t_prev_start = t_start;
        t_start      = cyc;
        if (!hold_start) start = 1'b0;
        check("clear_on_start", (C === '0), 1);
        check("fifo_en_in_run", fifo_en, 1);
        e = 0;
        while (fifo_en && e < RUN_CYCLES + 8) begin
            drive_edge(e);
            if (e == extra_start_at) start = 1'b1;
            else if (!hold_start)    start = 1'b0;
            if (e == rst_at) begin
                rst = 1'b1;
                #1;
                check("rst_fifo_en", fifo_en, 0);
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_c_zero", (C === '0), 1);
                exp_q.delete();
                #2 rst = 1'b0;
                start = 1'b0;
                return;
            end
            @(posedge clk); #1;
            e++;
        end
        A = '0;
        B = '0;
        check("run_length", e, RUN_CYCLES);
        check("done_pulse", done, 1);
        check("done_latency", cyc - t_req, RUN_CYCLES + 1);
        for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < DIM; j++) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_empty", 0, 1);
                end else begin
                    last_exp[i][j] = exp_q.pop_front();
                    check($sformatf("c_%0d_%0d", i, j), C[i][j], last_exp[i][j]);
                end
            end
        end
    endtask

    initial begin
        int extra_done;
        int hold_ok;

        rst   = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        t_start      = 0;
        t_prev_start = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_fifo_en", fifo_en, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_c_zero", (C === '0), 1);
        rst = 1'b0;
        @(posedge clk); #1;

        // identity x 1..64 gives B back
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                ma[i][j] = (i == j) ? 1 : 0;
                mb[i][j] = i*DIM + j + 1;
            end
        run_job(-1, -1, 1'b0);
        for (int j = 0; j < DIM; j++) check("identity_row0", C[0][j], j + 1);

        // -128 * -128 * 8 wraps to zero
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                ma[i][j] = -128;
                mb[i][j] = -128;
            end
        run_job(-1, -1, 1'b0);

        // all threes: 8 * 9 = 72
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                ma[i][j] = 3;
                mb[i][j] = 3;
            end
        run_job(-1, -1, 1'b0);
        check("threes_c77", C[DIM-1][DIM-1], 72);

        // hold after done while inputs toggle
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < DIM; i++) begin
                A[i] = BITS_AB'($urandom);
                B[i] = BITS_AB'($urandom);
            end
            @(posedge clk); #1;
            hold_ok = 1;
            for (int i = 0; i < DIM; i++)
                for (int j = 0; j < DIM; j++)
                    if (C[i][j] !== last_exp[i][j]) hold_ok = 0;
            check("hold_after_done", hold_ok, 1);
        end
        A = '0;
        B = '0;

        // start pulse mid-run is ignored; only one done follows
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                ma[i][j] = int'($urandom_range(0, 255)) - 128;
                mb[i][j] = int'($urandom_range(0, 255)) - 128;
            end
        run_job(5, -1, 1'b0);
        extra_done = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (done) extra_done++;
        end
        check("single_done", extra_done, 0);
        check("idle_after_ignored_start", busy, 0);

        // reset mid-run, then a fresh job
        run_job(-1, 10, 1'b0);
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                ma[i][j] = int'($urandom_range(0, 255)) - 128;
                mb[i][j] = int'($urandom_range(0, 255)) - 128;
            end
        run_job(-1, -1, 1'b0);

        // start held high: jobs restart back to back
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < DIM; i++)
                for (int j = 0; j < DIM; j++) begin
                    ma[i][j] = int'($urandom_range(0, 255)) - 128;
                    mb[i][j] = int'($urandom_range(0, 255)) - 128;
                end
            run_job(-1, -1, 1'b1);
            if (n > 0) check("job_spacing", t_start - t_prev_start, RUN_CYCLES + 2);
        end
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("final_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
